as6501_serial_tx: RTL
=====================

Name: as6501_serial_tx

Overview:
- Transmit-side model of the AS6501 TDC serial result port. It is the counterpart of the TDC receive interface that samples frame/sdi.
- Accepts {REF_INDEX, STOP} result words on an AXI-Stream slave and buffers them in a small FIFO.
- Serialises each word MSB-first on sdi_o, with a frame_o pulse marking the start of each result.
- Used in TDC-less lab builds and in loopback benches to drive the receive interface with known timestamps.

Parameters:
- INDEX_W, 4, REF_INDEX field width in bits (1..24).
- STOP_W, 14, STOP field width in bits (1..24).
- FRAME_HI, 8, number of cycles frame_o stays high at frame start (1..INDEX_W+STOP_W).
- GAP, 2, idle cycles between the last bit of one frame and the first bit of the next (>=1).
- DEPTH_LOG2, 3, log2 of FIFO depth (depth 8 by default).

Ports:
- lclk_i  in  1  bit clock; one serial bit per cycle (SDR).
- arstn  in  1  asynchronous active-low reset.
- enable_i  in  1  allows new frames to start.
- s_axis_tdata  in  INDEX_W+STOP_W  result word {index, stop}; index occupies the MSBs.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  FIFO can accept a word.
- frame_o  out  1  frame marker to the receiver.
- sdi_o  out  1  serial data to the receiver.
- busy_o  out  1  high while in SHIFT or GAP.
- fifo_level_o  out  DEPTH_LOG2+1  current FIFO occupancy.
- frames_sent_o  out  16  count of completed frames; wraps.

Behaviour:
- N = INDEX_W+STOP_W. All outputs are registered.
- Reset (arstn=0, asynchronous):
  - frame_o=0, sdi_o=0, busy_o=0, s_axis_tready=0, fifo_level_o=0, frames_sent_o=0.
  - FIFO is emptied and the FSM returns to IDLE.
  - This applies mid-frame too: the partial frame is abandoned and not counted.
- Input handshake:
  - s_axis_tready = !full. It reads 1 from the first cycle after reset release.
  - A push happens when tvalid && tready.
  - There is no pass-through: a full FIFO deasserts tready even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves the level unchanged.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If enable_i && !empty at cycle t, the FSM pops the head word into a shift register and enters SHIFT.
  - frame_o=1 and sdi_o=bit N-1 appear at t+1.
- SHIFT:
  - Bit N-1-k is driven at cycle t+1+k, for k=0..N-1.
  - frame_o is high for cycles t+1..t+FRAME_HI.
  - After the last bit the FSM enters GAP; frames_sent_o increments at the same edge that drives the last bit.
- GAP:
  - sdi_o=0 and frame_o=0 for exactly GAP cycles.
  - On the final GAP cycle, if enable_i && !empty, the FSM pops and goes directly to SHIFT. Back-to-back frames therefore have exactly GAP idle cycles between them.
  - Otherwise the FSM goes to IDLE.
- In IDLE, sdi_o=0 and frame_o=0.
- enable_i deassert mid-frame: the current frame and its GAP complete; no new frame starts. Reassertion resumes from the FIFO head.
- Empty FIFO with enable_i=1: the FSM stays in IDLE and the outputs stay low.
- Frame period with a continuous supply is N+GAP cycles. With defaults that is 20 cycles (100 ns at 200 MHz).
- frames_sent_o wraps from 0xFFFF to 0x0000.
- FRAME_HI > N is illegal; the block must raise a simulation error under synthesis translate_off.

Test Plan:
- Single frame, defaults:
  - Stimulus: push 0x29234 (index 0xA, stop 0x1234) with enable_i=1.
  - Required: sdi_o carries 10 1001 0010 0011 0100 over 18 consecutive cycles starting one cycle after the pop.
  - Required: frame_o is high for the first 8 of those cycles; frames_sent_o=1; busy_o falls 2 cycles after the last bit.
- Back-to-back:
  - Stimulus: push 0x00001, 0x3FFFF, 0x15555 in consecutive cycles.
  - Required: three frames with exactly 2 zero cycles between them; first bits are 20 cycles apart; frames_sent_o=3; fifo_level_o returns to 0.
- FIFO full:
  - Stimulus: enable_i=0, hold tvalid for 10 cycles.
  - Required: 8 words accepted; tready=0 from the 9th cycle; fifo_level_o=8.
  - Then set enable_i=1: tready returns 1 on the cycle after the first pop.
- Enable drop mid-frame:
  - Stimulus: deassert enable_i at bit 5 with 2 words queued.
  - Required: the first frame completes all 18 bits; the second does not start until enable_i returns; fifo_level_o=1 meanwhile.
- Reset mid-frame:
  - Stimulus: pull arstn low at bit 9.
  - Required: sdi_o and frame_o go 0 immediately (asynchronously); fifo_level_o=0; frames_sent_o=0; no frame after release until a new push.
- Loopback:
  - Stimulus: connect to the TDC receive interface and send 16 random words.
  - Required: the receiver reports identical index/stop values, in order, with no drops.

Source files
------------

// File: rtl/as6501_serial_tx_if.sv
// AXI-Stream channel carrying {REF_INDEX, STOP} result words into the AS6501 serial transmitter.
interface as6501_serial_tx_if #(
    parameter int DATA_W = 18
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;

    modport master (output s_axis_tdata, output s_axis_tvalid, input s_axis_tready);
    modport slave  (input s_axis_tdata, input s_axis_tvalid, output s_axis_tready);
endinterface

// File: rtl/as6501_serial_tx.sv
// AS6501 serial result-port transmitter: buffers result words in a FIFO and
// shifts each one out MSB-first on sdi_o with a frame_o marker at its start.
module as6501_serial_tx #(
    parameter int INDEX_W    = 4,
    parameter int STOP_W     = 14,
    parameter int FRAME_HI   = 8,
    parameter int GAP        = 2,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                    lclk_i,
    input  logic                    arstn,
    input  logic                    enable_i,
    as6501_serial_tx_if.slave       s_axis,
    output logic                    frame_o,
    output logic                    sdi_o,
    output logic                    busy_o,
    output logic [DEPTH_LOG2:0]     fifo_level_o,
    output logic [15:0]             frames_sent_o
);
    localparam int N     = INDEX_W + STOP_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(N + 1);
    localparam int GW    = $clog2(GAP + 1);

    localparam logic [CW-1:0]         C_LAST   = CW'(N);
    localparam logic [CW-1:0]         C_PENULT = CW'(N - 1);
    localparam logic [CW-1:0]         C_FHI    = CW'(FRAME_HI);
    localparam logic [GW-1:0]         C_GAP    = GW'(GAP);
    localparam logic [DEPTH_LOG2:0]   C_DEPTH  = (DEPTH_LOG2 + 1)'(DEPTH);

    if (FRAME_HI > N || FRAME_HI < 1) begin : g_bad_frame_hi
        $error("as6501_serial_tx: FRAME_HI must lie in 1..INDEX_W+STOP_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    logic [N-1:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_tready;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [GW-1:0]         r_gap;
    logic [N-1:0]          r_shift;
    logic                  r_sdi;
    logic                  r_frame;
    logic                  r_busy;
    logic [15:0]           r_frames;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [DEPTH_LOG2:0]   w_level_nxt;
    logic [N-1:0]          w_head;

    assign w_empty = (r_level == '0);
    assign w_push  = s_axis.s_axis_tvalid && r_tready;
    assign w_head  = r_mem[r_rptr];
    // A new frame may only be launched from IDLE or from the last GAP cycle.
    assign w_pop   = enable_i && !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap == C_GAP)));

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + 1'b1;
        else if (w_pop && !w_push)
            w_level_nxt = r_level - 1'b1;
    end

    always_ff @(posedge lclk_i) begin
        if (w_push)
            r_mem[r_wptr] <= s_axis.s_axis_tdata;
    end

    // r_shift holds the bits still to be driven, next one in the MSB.
    always_ff @(posedge lclk_i) begin
        if (w_pop)
            r_shift <= w_head << 1;
        else if (r_state == S_SHIFT)
            r_shift <= r_shift << 1;
    end

    always_ff @(posedge lclk_i or negedge arstn) begin
        if (!arstn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_tready <= 1'b0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_sdi    <= 1'b0;
            r_frame  <= 1'b0;
            r_busy   <= 1'b0;
            r_frames <= '0;
        end else begin
            r_level  <= w_level_nxt;
            r_tready <= (w_level_nxt != C_DEPTH);
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;

            if (w_pop) begin
                r_state <= S_SHIFT;
                r_cnt   <= CW'(1);
                r_sdi   <= w_head[N-1];
                r_frame <= 1'b1;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        // r_cnt is the number of bits already on the line.
                        if (r_cnt == C_LAST) begin
                            r_state <= S_GAP;
                            r_gap   <= GW'(1);
                            r_sdi   <= 1'b0;
                            r_frame <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_sdi   <= r_shift[N-1];
                            r_frame <= (r_cnt < C_FHI);
                            if (r_cnt == C_PENULT)
                                r_frames <= r_frames + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_gap == C_GAP) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_sdi   <= 1'b0;
                        r_frame <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_axis.s_axis_tready = r_tready;
    assign frame_o              = r_frame;
    assign sdi_o                = r_sdi;
    assign busy_o               = r_busy;
    assign fifo_level_o         = r_level;
    assign frames_sent_o        = r_frames;

endmodule
